hex_display_driver: RTL and testbench
=====================================

# hex_display_driver

Drives the six active-low seven-segment displays HEX0..HEX5 from the six digit codes produced by the main 7-segment controller. Digit codes are committed only after they have been stable for a set number of cycles, so the combinational switch decoding upstream cannot cause visible glitches. Each committed code is decoded to a registered segment pattern. Selected digits can optionally blink.

## Interface
- STABLE_CYCLES, 16: cycles the inputs must remain unchanged before they are committed; must be ≥1.
- BLINK_DIV, 25_000_000: blink half-period in clock cycles; must be ≥1.
- CLOCK_50  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- num0..num5  input  32 each  digit codes: 0–9 show a digit, 10 shows blank, any other value shows a dash.
- blink_mask  input  6  bit i set means HEXi blinks (only when HEX_BLINK_EN is defined).
- HEX0..HEX5  output  7 each  segments a..g on bits 0..6, active-low, registered.
- updated  output  1  one-cycle pulse when a new set of codes is committed.

## Operation
- Registers:
  - snap[0:5]: 32-bit snapshot of the inputs.
  - cur[0:5]: committed codes.
  - cnt: stability counter, width $clog2(STABLE_CYCLES+1).
  - state.
- Reset values:
  - state=IDLE, cnt=0, snap=cur=all 10.
  - HEX0..HEX5=7'h7F (all segments off).
  - updated=0, blink phase=0, blink counter=0.
- Comparisons between inputs, snap and cur use the full 32-bit width of all six codes.
- IDLE:
  - If inputs ≠ cur: snap←inputs, cnt←0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - If inputs = cur: go to IDLE. No commit, no pulse.
  - Else if inputs ≠ snap: snap←inputs, cnt←0.
  - Else if cnt = STABLE_CYCLES−1: go to COMMIT.
  - Else cnt←cnt+1.
- COMMIT:
  - cur←snap, updated←1 for exactly this one cycle, go to IDLE.
  - Inputs are ignored in this cycle; any difference is detected in IDLE on the next cycle.
- Decoding:
  - HEXi is registered every cycle from decode(cur[i]).
  - Code 0 = 7'b1000000; code 8 = 7'b0000000; code 10 = 7'h7F; any invalid code = 7'b0111111 (dash).
- Reset asserted mid-SETTLE or mid-COMMIT: all state returns to the reset values immediately and asynchronously. Nothing is committed.

## Timing
- Inputs change and are first sampled at edge k (IDLE→SETTLE).
- If they stay stable, state enters COMMIT at edge k+STABLE_CYCLES.
- cur and updated become valid at edge k+STABLE_CYCLES+1.
- HEX outputs show the new codes at edge k+STABLE_CYCLES+2.
- Any input change before COMMIT restarts the count from the edge at which it is sampled.
- A change that reverts to cur inside the window produces no update.
- Blink:
  - The blink counter counts 0..BLINK_DIV−1, then wraps and toggles the phase.
  - The phase is therefore 1 for BLINK_DIV cycles out of every 2·BLINK_DIV.
  - The blink counter runs freely and independently of the state machine.

## Configuration
- HEX_BLINK_EN:
  - Defined: the blink counter and phase register are present. When phase=1 and blink_mask[i]=1, HEXi is registered as 7'h7F; otherwise HEXi shows the decoded glyph. blink_mask is sampled every cycle.
  - Undefined: no blink counter or phase register. blink_mask is present but ignored. HEXi always shows the decoded glyph.

## Structure
- Package hex_display_pkg holds:
  - state enum {IDLE, SETTLE, COMMIT}
  - BLANK_CODE=10
  - SEG_OFF=7'h7F
  - SEG_DASH=7'b0111111
  - glyph constants for 0–9
- Sub-module seg7_decode: purely combinational, 32-bit code in, 7-bit active-low pattern out. Instantiated six times.

## Test plan
- Reset: hold reset_n=0 → HEX0..5=7'h7F and updated=0. Release reset → outputs remain 7'h7F.
- Commit: STABLE_CYCLES=4; drive codes 3,2,7,6,1,9 at edge k → one updated pulse at k+5, HEX0=7'b0110000 at k+6.
- Glitch: with STABLE_CYCLES=4, toggle num2 every 2 cycles for 20 cycles → no updated pulse and HEX unchanged. After the inputs settle, commit occurs 5 edges after the last change.
- Revert: set all inputs to 10, change num0 to 5 for 2 cycles, then back to 10 → returns to IDLE with no pulse.
- Invalid code: num4=11 → HEX4=7'b0111111 after commit.
- Blink (HEX_BLINK_EN defined, BLINK_DIV=3): blink_mask=6'b000001 → HEX0 alternates glyph/off every 3 cycles while HEX1..5 stay steady. Asserting reset mid-SETTLE → all outputs off, nothing committed.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for hex_display_driver (active-low, a..g on bits 0..6).
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMMIT
    } state_t;

    localparam logic [31:0] BLANK_CODE = 32'd10;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [6:0]  SEG_DASH   = 7'b0111111;

    // Index n holds the glyph for digit n.
    localparam logic [9:0][6:0] GLYPHS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_display_driver_seg7_decode.sv
// Combinational digit-code to active-low seven-segment decoder: 0-9 digit, 10 blank, else dash.
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [31:0] i_code,
    output logic [6:0]  o_seg
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_seg and no latch is inferred.
        o_seg = SEG_DASH;
        if (i_code < 32'd10) begin
            o_seg = GLYPHS[i_code[3:0]];
        end else if (i_code == BLANK_CODE) begin
            o_seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/hex_display_driver.sv
// Debounced six-digit seven-segment driver; codes commit after STABLE_CYCLES of stability.
// Optional per-digit blinking is built only when HEX_BLINK_EN is defined.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int BLINK_DIV     = 25_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [31:0] num0,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [31:0] num3,
    input  logic [31:0] num4,
    input  logic [31:0] num5,
    input  logic [5:0]  blink_mask,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        updated
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [5:0][31:0] w_num;
    logic [5:0][31:0] r_snap;
    logic [5:0][31:0] r_cur;
    logic [CW-1:0]    r_cnt;
    state_t           r_state;
    logic             r_updated;
    logic [5:0][6:0]  w_glyph;
    logic [5:0][6:0]  r_hex;
    logic [5:0]       w_blank;

    assign w_num = {num5, num4, num3, num2, num1, num0};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_snap    <= {6{BLANK_CODE}};
            r_cur     <= {6{BLANK_CODE}};
            r_updated <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_updated <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_num != r_cur) begin
                        r_snap  <= w_num;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_num == r_cur) begin
                        r_state <= IDLE;
                    end else if (w_num != r_snap) begin
                        r_snap <= w_num;
                        r_cnt  <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= COMMIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    // Inputs are not looked at here; IDLE catches any difference next cycle.
                    r_cur     <= r_snap;
                    r_updated <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_dec
        seg7_decode u_dec (
            .i_code (r_cur[g]),
            .o_seg  (w_glyph[g])
        );
    end

`ifdef HEX_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign w_blank = r_phase ? blink_mask : 6'b0;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^blink_mask;
    assign w_blank       = 6'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= {6{SEG_OFF}};
        end else begin
            for (int i = 0; i < 6; i++) begin
                r_hex[i] <= w_blank[i] ? SEG_OFF : w_glyph[i];
            end
        end
    end

    assign HEX0    = r_hex[0];
    assign HEX1    = r_hex[1];
    assign HEX2    = r_hex[2];
    assign HEX3    = r_hex[3];
    assign HEX4    = r_hex[4];
    assign HEX5    = r_hex[5];
    assign updated = r_updated;

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver: table vectors, hand sequences and random stimulus
// against a timestamp-based reference model; blink checks are active when HEX_BLINK_EN is defined.
module tb_hex_display_driver;

    localparam int STABLE    = 4;
    localparam int BLINK_DIV = 3;

    logic             clk;
    logic             reset_n;
    bit   [5:0][31:0] drv;
    logic [5:0]       mask;
    logic [6:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic             updated;

    int n_total = 0;
    int n_bad   = 0;

    hex_display_driver #(
        .STABLE_CYCLES (STABLE),
        .BLINK_DIV     (BLINK_DIV)
    ) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .num0       (drv[0]),
        .num1       (drv[1]),
        .num2       (drv[2]),
        .num3       (drv[3]),
        .num4       (drv[4]),
        .num5       (drv[5]),
        .blink_mask (mask),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .updated    (updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lit segments of each digit, by letter.
    string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] glyph(input bit [31:0] c);
        logic [6:0] p;
        string      s;
        if (c == 32'd10) return 7'h7F;
        if (c > 32'd10)  return 7'b0111111;
        p = 7'h7F;
        s = SEGS[c];
        for (int j = 0; j < s.len(); j++) p[int'(s[j]) - 97] = 1'b0;
        return p;
    endfunction

    // Reference model: a code set commits once it has been seen unchanged for STABLE
    // edges after its first sample, unless it reverts to the committed set first.
    bit [5:0][31:0] m_cur, m_snap;
    bit             m_pending;
    int             m_e, m_since, m_commit_at;

    task automatic model_reset();
        m_cur       = {6{32'd10}};
        m_snap      = {6{32'd10}};
        m_pending   = 1'b0;
        m_e         = 0;
        m_since     = 0;
        m_commit_at = -1;
    endtask

    task automatic model_edge(input bit [5:0][31:0] v, input logic [5:0] mk,
                              output logic [5:0][6:0] eh, output logic eu);
        bit phase;
        m_e++;
`ifdef HEX_BLINK_EN
        phase = (((m_e - 1) / BLINK_DIV) % 2) == 1;
`else
        phase = 1'b0;
`endif
        for (int i = 0; i < 6; i++) eh[i] = (phase && mk[i]) ? 7'h7F : glyph(m_cur[i]);
        eu = (m_commit_at == m_e);
        if (eu) begin
            m_cur     = m_snap;
            m_pending = 1'b0;
        end else if (v == m_cur) begin
            m_pending = 1'b0;
        end else if (!m_pending || v != m_snap) begin
            m_pending = 1'b1;
            m_snap    = v;
            m_since   = m_e;
        end else if (m_e - m_since == STABLE) begin
            m_commit_at = m_e + 1;
            m_pending   = 1'b0;
        end
    endtask

    // One clock edge: model the edge, then compare every output 1 time unit later.
    task automatic step();
        bit   [5:0][31:0] v;
        logic [5:0]       mk;
        logic [5:0][6:0]  eh;
        logic             eu;
        v  = drv;
        mk = mask;
        @(posedge clk);
        model_edge(v, mk, eh, eu);
        #1;
        check("hex_upd", {updated, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {eu, eh});
    endtask

    function automatic logic [41:0] hex_all();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    typedef struct {
        bit   [5:0][31:0] codes;
        logic [5:0][6:0]  hex;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int pulses;
        int n;
        int off_cnt;

        reset_n = 1'b0;
        drv     = {6{32'd10}};
        mask    = 6'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_hex", 64'(hex_all()), 64'({6{7'h7F}}));
        check("reset_upd", 64'(updated), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("post_reset_hex", 64'(hex_all()), 64'({6{7'h7F}}));

        // Commit latency: codes 3,2,7,6,1,9 sampled at edge k
        drv = {32'd9, 32'd1, 32'd6, 32'd7, 32'd2, 32'd3};
        step();
        pulses = 0;
        repeat (4) begin
            step();
            pulses += int'(updated);
        end
        check("commit_early_pulse", 64'(pulses), 64'(0));
        step();
        check("commit_pulse_k5", 64'(updated), 64'(1));
        check("commit_hex0_k5", 64'(HEX0), 64'(7'h7F));
        step();
        check("commit_hex0_k6", 64'(HEX0), 64'(7'b0110000));
        check("commit_pulse_k6", 64'(updated), 64'(0));

        // Table-driven decode vectors
        vecs[0].codes = {32'd9, 32'd1, 32'd6, 32'd7, 32'd2, 32'd0};
        vecs[0].hex   = {7'b0010000, 7'b1111001, 7'b0000010, 7'b1111000, 7'b0100100, 7'b1000000};
        vecs[1].codes = {32'd5, 32'd11, 32'd4, 32'd10, 32'd8, 32'd0};
        vecs[1].hex   = {7'b0010010, 7'b0111111, 7'b0011001, 7'h7F, 7'b0000000, 7'b1000000};
        vecs[2].codes = {32'd12, 32'd1, 32'd9, 32'h1000_0003, 32'h0000_0100, 32'hFFFF_FFFF};
        vecs[2].hex   = {7'b0111111, 7'b1111001, 7'b0010000, 7'b0111111, 7'b0111111, 7'b0111111};
        vecs[3].codes = {6{32'd10}};
        vecs[3].hex   = {6{7'h7F}};
        for (int t = 0; t < 4; t++) begin
            drv = vecs[t].codes;
            repeat (8) step();
            check($sformatf("table_%0d", t), 64'(hex_all()), 64'(vecs[t].hex));
        end

        // Revert inside the window: no update
        drv[0] = 32'd5;
        repeat (2) step();
        drv[0] = 32'd10;
        pulses = 0;
        repeat (8) begin
            step();
            pulses += int'(updated);
        end
        check("revert_pulses", 64'(pulses), 64'(0));
        check("revert_hex0", 64'(HEX0), 64'(7'h7F));

        // Glitch: num2 toggles every 2 cycles for 20 cycles
        pulses = 0;
        for (int t = 0; t < 10; t++) begin
            drv[2] = (t % 2 == 0) ? 32'd4 : 32'd5;
            repeat (2) begin
                step();
                pulses += int'(updated);
            end
        end
        check("glitch_pulses", 64'(pulses), 64'(0));
        check("glitch_hex2", 64'(HEX2), 64'(7'h7F));
        drv[2] = 32'd6;
        n = 0;
        do begin
            step();
            n++;
        end while (!updated && n < 20);
        check("glitch_settle_edges", 64'(n - 1), 64'(STABLE + 1));
        step();
        check("glitch_hex2_after", 64'(HEX2), 64'(7'b0000010));

        // Invalid code on HEX4
        drv[4] = 32'd11;
        repeat (8) step();
        check("invalid_hex4", 64'(HEX4), 64'(7'b0111111));

`ifdef HEX_BLINK_EN
        drv = {6{32'd8}};
        repeat (8) step();
        mask    = 6'b000001;
        off_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            off_cnt += int'(HEX0 == 7'h7F);
            check("blink_hex1_steady", 64'(HEX1), 64'(7'b0000000));
        end
        check("blink_off_count", 64'(off_cnt), 64'(6));
        mask = 6'b0;
`else
        off_cnt = 0;
`endif

        // Reset asserted mid-SETTLE
        drv = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_hex", 64'(hex_all()), 64'({6{7'h7F}}));
        check("midreset_upd", 64'(updated), 64'(0));
        drv = {6{32'd10}};
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        pulses = 0;
        repeat (8) begin
            step();
            pulses += int'(updated);
        end
        check("midreset_no_commit", 64'(pulses), 64'(0));
        check("midreset_hex_after", 64'(hex_all()), 64'({6{7'h7F}}));

        // Random stimulus against the model
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(0, 7) == 0) begin
                drv = m_cur;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drv[i] = ($urandom_range(0, 15) == 0) ? $urandom()
                                                              : 32'($urandom_range(0, 12));
                    end
                end
            end
            mask = 6'($urandom());
            repeat ($urandom_range(1, 7)) step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
